// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC generator with credit-limited in-order imem requests and a fetch queue.
// Optional performance counters are enabled by defining IF_FETCH_PERF_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_VEC       = 32'h6000_0000,
  parameter int unsigned FQ_DEPTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_next
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] o_perf_fetched,
  output logic [31:0] o_perf_dropped
`endif
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthC  = CW'(FQ_DEPTH);
  localparam logic [CW-1:0] MaxOutC = CW'(MAX_OUTSTANDING);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] fq_cnt_q, fq_cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   fq_inst_q [FQ_DEPTH];
  logic [31:0]   fq_pc_q   [FQ_DEPTH];

  logic          head_valid, pop, resp_live, resp_drop, issue;
  logic [CW-1:0] out_after, drop_after, fq_after, live_after;
  logic [CW:0]   credit_sum;

  always_comb begin
    head_valid = (fq_cnt_q != '0) && !i_redirect;
    pop        = head_valid && i_ready;
    // A response arriving with a redirect belongs to the old stream and is always discarded.
    resp_live  = imem_resp && (drop_cnt_q == '0) && !i_redirect;
    resp_drop  = imem_resp && !resp_live;

    out_after  = out_cnt_q - CW'(imem_resp);
    drop_after = i_redirect ? out_after : (drop_cnt_q - CW'(resp_drop));
    fq_after   = i_redirect ? '0 : (fq_cnt_q + CW'(resp_live) - CW'(pop));
    live_after = out_after - drop_after;
    credit_sum = {1'b0, live_after} + {1'b0, fq_after};

    issue      = !rst && (out_after < MaxOutC) && (credit_sum < {1'b0, DepthC});

    imem_addr  = i_redirect ? i_redirect_pc : pc_q;
    imem_rmask = issue ? 4'hF : 4'h0;

    pc_d       = issue ? (imem_addr + 32'd4) : imem_addr;
    resp_pc_d  = resp_pc_q;
    if (i_redirect) begin
      resp_pc_d = i_redirect_pc;
    end else if (resp_live) begin
      resp_pc_d = resp_pc_q + 32'd4;
    end

    out_cnt_d  = out_after + CW'(issue);
    drop_cnt_d = drop_after;
    fq_cnt_d   = fq_after;
    wr_ptr_d   = i_redirect ? '0 : (wr_ptr_q + PW'(resp_live));
    rd_ptr_d   = i_redirect ? '0 : (rd_ptr_q + PW'(pop));

    o_valid    = head_valid;
    o_inst     = (fq_cnt_q != '0) ? fq_inst_q[rd_ptr_q] : 32'd0;
    o_pc       = (fq_cnt_q != '0) ? fq_pc_q[rd_ptr_q] : 32'd0;
    o_pc_next  = (fq_cnt_q != '0) ? (fq_pc_q[rd_ptr_q] + 32'd4) : 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      resp_pc_q  <= RESET_VEC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      fq_cnt_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fq_cnt_q   <= fq_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Queue storage needs no reset: entries are only visible while fq_cnt_q is non-zero.
  always_ff @(posedge clk) begin
    if (resp_live) begin
      fq_inst_q[wr_ptr_q] <= imem_rdata;
      fq_pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(pop);
    perf_dropped_d = perf_dropped_q + 32'(resp_drop);
    o_perf_fetched = perf_fetched_q;
    o_perf_dropped = perf_dropped_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= 32'd0;
      perf_dropped_q <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit with a small in-order imem responder of
// configurable latency; each row gives per-cycle inputs and the expected outputs.
module tb_if_fetch_unit;

  localparam logic [31:0] B        = 32'h6000_0000;
  localparam int          FQ_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic [31:0] o_pc_next;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] o_perf_fetched;
  logic [31:0] o_perf_dropped;
`endif

  if_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rmask    (imem_rmask),
    .imem_rdata    (imem_rdata),
    .imem_resp     (imem_resp),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_inst        (o_inst),
    .o_pc          (o_pc),
    .o_pc_next     (o_pc_next)
`ifdef IF_FETCH_PERF_EN
    ,
    .o_perf_fetched(o_perf_fetched),
    .o_perf_dropped(o_perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          redir;
    logic [31:0] rpc;
    bit          rdy;
    int          lat;
    bit          rm;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
    bit          pchk;
    logic [31:0] pfetch;
    logic [31:0] pdrop;
  } row_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  row_t vec[$];
  req_t mq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc;
  row_t r;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input bit rs, input bit rd, input logic [31:0] rpc, input bit rdy,
                     input int lat, input bit rm, input logic [31:0] addr, input bit vld,
                     input logic [31:0] pc, input bit pchk, input logic [31:0] pf,
                     input logic [31:0] pd);
    row_t x;
    x = '{rst: rs, redir: rd, rpc: rpc, rdy: rdy, lat: lat, rm: rm, addr: addr, vld: vld,
          pc: pc, pchk: pchk, pfetch: pf, pdrop: pd};
    vec.push_back(x);
  endtask

  task automatic n(input bit rdy, input int lat, input bit rm, input logic [31:0] addr,
                   input bit vld, input logic [31:0] pc);
    add(0, 0, 0, rdy, lat, rm, addr, vld, pc, 0, 0, 0);
  endtask

  task automatic rd(input logic [31:0] rpc, input bit rdy, input int lat, input bit rm,
                    input logic [31:0] addr);
    add(0, 1, rpc, rdy, lat, rm, addr, 0, 0, 0, 0, 0);
  endtask

  task automatic rs();
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0; i_ready = 1'b0;
    imem_resp = 1'b0; imem_rdata = '0;

    // Streaming, 1-cycle imem
    n(1, 1, 1, B + 32'h0,  0, 0);
    n(1, 1, 1, B + 32'h4,  0, 0);
    n(1, 1, 1, B + 32'h8,  1, B + 32'h0);
    n(1, 1, 1, B + 32'hC,  1, B + 32'h4);
    n(1, 1, 1, B + 32'h10, 1, B + 32'h8);
    rs();
    // Decode stalled: queue fills after 4 requests; one pop gives one issue
    n(0, 1, 1, B + 32'h0,  0, 0);
    n(0, 1, 1, B + 32'h4,  0, 0);
    n(0, 1, 1, B + 32'h8,  1, B);
    n(0, 1, 1, B + 32'hC,  1, B);
    n(0, 1, 0, 0,          1, B);
    n(0, 1, 0, 0,          1, B);
    n(1, 1, 1, B + 32'h10, 1, B);
    n(0, 1, 0, 0,          1, B + 32'h4);
    rs();
    // 3-cycle imem: outstanding limit of 2
    n(1, 3, 1, B + 32'h0,  0, 0);
    n(1, 3, 1, B + 32'h4,  0, 0);
    n(1, 3, 0, 0,          0, 0);
    n(1, 3, 1, B + 32'h8,  0, 0);
    n(1, 3, 1, B + 32'hC,  1, B);
    n(1, 3, 0, 0,          1, B + 32'h4);
    n(1, 3, 1, B + 32'h10, 0, 0);
    n(1, 3, 1, B + 32'h14, 1, B + 32'h8);
    // Redirect with 2 outstanding: both stale responses dropped
    rd(B + 32'h1000, 1, 3, 0, 0);
    n(1, 3, 1, B + 32'h1000, 0, 0);
    n(1, 3, 1, B + 32'h1004, 0, 0);
    add(0, 0, 0, 1, 3, 0, 0, 0, 0, 1, 32'd3, 32'd2);
    n(1, 3, 1, B + 32'h1008, 0, 0);
    n(1, 3, 1, B + 32'h100C, 1, B + 32'h1000);
    rs();
    // Redirect coincident with response and ready head; then back-to-back redirects
    n(1, 1, 1, B + 32'h0, 0, 0);
    n(1, 1, 1, B + 32'h4, 0, 0);
    n(1, 1, 1, B + 32'h8, 1, B);
    rd(B + 32'h2000, 1, 1, 1, B + 32'h2000);
    n(1, 1, 1, B + 32'h2004, 0, 0);
    n(1, 1, 1, B + 32'h2008, 1, B + 32'h2000);
    n(1, 1, 1, B + 32'h200C, 1, B + 32'h2004);
    rd(B + 32'h3000, 1, 1, 1, B + 32'h3000);
    rd(B + 32'h4000, 1, 1, 1, B + 32'h4000);
    add(0, 0, 0, 1, 1, 1, B + 32'h4004, 0, 0, 1, 32'd3, 32'd3);
    n(1, 1, 1, B + 32'h4008, 1, B + 32'h4000);
    rs();
    // Build up queue + 2 outstanding, then reset mid-operation
    n(0, 3, 1, B + 32'h0, 0, 0);
    n(0, 3, 1, B + 32'h4, 0, 0);
    n(0, 3, 0, 0,         0, 0);
    n(0, 3, 1, B + 32'h8, 0, 0);
    n(0, 3, 1, B + 32'hC, 1, B);
    n(0, 3, 0, 0,         1, B);
    rs();
    n(1, 1, 1, B + 32'h0, 0, 0);
    n(1, 1, 1, B + 32'h4, 0, 0);
    n(1, 1, 1, B + 32'h8, 1, B);

    repeat (2) @(negedge clk);
    #1;
    chk32("reset_rmask", {28'd0, imem_rmask}, 32'd0);
    chk32("reset_valid", {31'd0, o_valid}, 32'd0);
    chk32("reset_pc", o_pc, 32'd0);
    chk32("reset_inst", o_inst, 32'd0);
    chk32("reset_pc_next", o_pc_next, 32'd0);

    cyc = 0;
    for (int i = 0; i < vec.size(); i++) begin
      r = vec[i];
      @(negedge clk);
      rst           = r.rst;
      i_redirect    = r.redir;
      i_redirect_pc = r.rpc;
      i_ready       = r.rdy;
      imem_resp     = 1'b0;
      imem_rdata    = '0;
      if (r.rst) begin
        mq.delete();
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_resp  = 1'b1;
        imem_rdata = inst_of(mq[0].addr);
        void'(mq.pop_front());
      end
      #1;
      chk32($sformatf("r%0d_rmask", i), {28'd0, imem_rmask}, r.rm ? 32'hF : 32'h0);
      if (r.rm) chk32($sformatf("r%0d_addr", i), imem_addr, r.addr);
      chk32($sformatf("r%0d_valid", i), {31'd0, o_valid}, {31'd0, r.vld});
      if (r.vld) begin
        chk32($sformatf("r%0d_pc", i), o_pc, r.pc);
        chk32($sformatf("r%0d_inst", i), o_inst, inst_of(r.pc));
        chk32($sformatf("r%0d_pc_next", i), o_pc_next, r.pc + 32'd4);
      end
      if (r.rst) begin
        chk32($sformatf("r%0d_rst_pc", i), o_pc, 32'd0);
        chk32($sformatf("r%0d_rst_inst", i), o_inst, 32'd0);
        chk32($sformatf("r%0d_rst_pc_next", i), o_pc_next, 32'd0);
      end
`ifdef IF_FETCH_PERF_EN
      if (r.pchk) begin
        chk32($sformatf("r%0d_perf_fetched", i), o_perf_fetched, r.pfetch);
        chk32($sformatf("r%0d_perf_dropped", i), o_perf_dropped, r.pdrop);
      end
`endif
      // A live response must never find the queue full.
      if (imem_resp && !i_redirect && dut.drop_cnt_q == '0) begin
        checks++;
        if (int'(dut.fq_cnt_q) >= FQ_DEPTH && !(o_valid && i_ready)) begin
          failures++;
          $display("FAIL r%0d_fq_overflow: actual fq_cnt=%0d required <%0d", i,
                   dut.fq_cnt_q, FQ_DEPTH);
        end
      end
      if (imem_rmask == 4'hF) mq.push_back('{addr: imem_addr, due: cyc + r.lat});
      cyc++;
    end

    @(negedge clk);
    i_ready   = 1'b0;
    imem_resp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
